s_axil_register: RTL and testbench

- Synthesizable AXI4-Lite slave exposing a bank of NUM_REG read/write registers.
- It is the responder end of the register-test master: the master's write/read sequences target this block.
- It accepts independent AW and W handshakes in any order, returns one B response per write and one R beat per read.
- It is the DUT on the register-test bench and the template register slave for future peripherals.

---
 rtl/s_axil_register_if.sv | 37 +++
 rtl/s_axil_register.sv | 224 ++++++++++++++++++++++
 tb/tb_s_axil_register.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/s_axil_register_if.sv
// AXI4-Lite register-slave bus bundle (AW, W, B, AR, R channels).
// Latency: none, wires only.
// Backpressure: carries VALID/READY per channel; master drives VALIDs, slave drives READYs.
// Ports: master modport drives addresses/data/strobes/VALIDs/BREADY/RREADY,
//        slave modport drives AWREADY/WREADY/ARREADY and the B/R response channels.
interface s_axil_register_if #(
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int S_AXI_ADDR_WIDTH = 32
);
  logic [S_AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic                          AWVALID;
  logic                          AWREADY;
  logic [S_AXI_DATA_WIDTH-1:0]   WDATA;
  logic [S_AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                          WVALID;
  logic                          WREADY;
  logic [1:0]                    BRESP;
  logic                          BVALID;
  logic                          BREADY;
  logic [S_AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic                          ARVALID;
  logic                          ARREADY;
  logic [S_AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                    RRESP;
  logic                          RVALID;
  logic                          RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/s_axil_register.sv
// AXI4-Lite slave holding NUM_REG 32-bit read/write registers at byte address 4*i.
// Latency: B valid 1 cycle after the edge where both AW and W are in; R valid 1 cycle after AR.
// Backpressure: one outstanding write and one outstanding read; READYs drop while a response waits.
// Ports: ACLK clock, ARESET async active-low reset, s_axil slave modport of the AXI4-Lite bundle.
module s_axil_register #(
  parameter int S_AXI_DATA_WIDTH = 32,  // byte lanes and word addressing assume 32
  parameter int S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_REG          = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  s_axil_register_if.slave s_axil
);

  localparam int STRB_W = S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam logic [S_AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = S_AXI_ADDR_WIDTH'(4 * NUM_REG);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_COLLECT, W_RESP } w_state_e;
  typedef enum logic { R_IDLE,    R_RESP } r_state_e;

  // ---------------------------------------------------------------- state
  w_state_e                    w_state_q, w_state_d;
  logic                        aw_held_q, aw_held_d;
  logic [IDX_W-1:0]            aw_idx_q,  aw_idx_d;
  logic                        aw_ok_q,   aw_ok_d;
  logic                        w_held_q,  w_held_d;
  logic [S_AXI_DATA_WIDTH-1:0] w_data_q,  w_data_d;
  logic [STRB_W-1:0]           w_strb_q,  w_strb_d;
  logic                        awready_q, awready_d;
  logic                        wready_q,  wready_d;
  logic                        bvalid_q,  bvalid_d;
  logic [1:0]                  bresp_q,   bresp_d;
  logic [S_AXI_DATA_WIDTH-1:0] regs_q [NUM_REG];
  logic [S_AXI_DATA_WIDTH-1:0] regs_d [NUM_REG];

  r_state_e                    r_state_q, r_state_d;
  logic                        arready_q, arready_d;
  logic                        rvalid_q,  rvalid_d;
  logic [S_AXI_DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]                  rresp_q,   rresp_d;

  // ---------------------------------------------------------------- decode
  // Addresses are decoded at handshake time, so only the word index and the
  // in-range flag need to be held while waiting for the partner channel.
  logic             aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0] aw_idx_in, ar_idx_in;
  logic             aw_ok_in, ar_ok_in;
  logic             unused_addr_lsbs;

  assign aw_hs     = s_axil.AWVALID & awready_q;
  assign w_hs      = s_axil.WVALID  & wready_q;
  assign ar_hs     = s_axil.ARVALID & arready_q;
  assign aw_idx_in = s_axil.AWADDR[IDX_W+1:2];
  assign ar_idx_in = s_axil.ARADDR[IDX_W+1:2];
  assign aw_ok_in  = (s_axil.AWADDR < ADDR_LIMIT);
  assign ar_ok_in  = (s_axil.ARADDR < ADDR_LIMIT);
  // Byte offset within a word carries no meaning for whole-register access.
  assign unused_addr_lsbs = ^{s_axil.AWADDR[1:0], s_axil.ARADDR[1:0]};

  // ---------------------------------------------------------------- write path
  logic                        wr_go;
  logic [IDX_W-1:0]            wr_idx;
  logic                        wr_ok;
  logic [S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]           wr_strb;

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    aw_ok_d   = aw_ok_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;

    // Each half comes either from its holding register or straight off the
    // bus when it handshakes this very cycle.
    wr_go   = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    wr_idx  = aw_held_q ? aw_idx_q : aw_idx_in;
    wr_ok   = aw_held_q ? aw_ok_q  : aw_ok_in;
    wr_data = w_held_q  ? w_data_q : s_axil.WDATA;
    wr_strb = w_held_q  ? w_strb_q : s_axil.WSTRB;

    case (w_state_q)
      W_COLLECT: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = aw_idx_in;
          aw_ok_d   = aw_ok_in;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = s_axil.WDATA;
          w_strb_d = s_axil.WSTRB;
        end
        if (wr_go) begin
          if (wr_ok) begin
            for (int k = 0; k < STRB_W; k++) begin
              if (wr_strb[k]) begin
                regs_d[wr_idx][8*k +: 8] = wr_data[8*k +: 8];
              end
            end
          end
          bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          bvalid_d  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          // A channel that has already delivered stays closed until its
          // partner shows up.
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      W_RESP: begin
        if (s_axil.BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_COLLECT;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  // ---------------------------------------------------------------- read path
  // regs_q (not regs_d) is sampled, so a write committing on the same edge
  // is not visible to this read.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d   = ar_ok_in ? regs_q[ar_idx_in] : '0;
          rresp_d   = ar_ok_in ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_RESP;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_RESP: begin
        if (s_axil.RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- flops
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      w_state_q <= W_COLLECT;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_REG; i++) begin
        regs_q[i] <= '0;
      end
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_ok_q   <= aw_ok_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign s_axil.AWREADY = awready_q;
  assign s_axil.WREADY  = wready_q;
  assign s_axil.BVALID  = bvalid_q;
  assign s_axil.BRESP   = bresp_q;
  assign s_axil.ARREADY = arready_q;
  assign s_axil.RVALID  = rvalid_q;
  assign s_axil.RDATA   = rdata_q;
  assign s_axil.RRESP   = rresp_q;

endmodule

// File: tb/tb_s_axil_register.sv
// Bench for s_axil_register: directed sequence with randomized data and channel delays.
// Latency: expects B/R one cycle after the completing address/data handshake.
// Backpressure: stalls BREADY/RREADY and skews AW vs W to exercise held responses.
module tb_s_axil_register;

  localparam int TMO = 200;

  logic ACLK   = 1'b0;
  logic ARESET = 1'b0;
  always #5 ACLK = ~ACLK;

  s_axil_register_if #(.S_AXI_DATA_WIDTH(32), .S_AXI_ADDR_WIDTH(32)) bus ();

  s_axil_register #(
    .S_AXI_DATA_WIDTH(32),
    .S_AXI_ADDR_WIDTH(32),
    .NUM_REG(16)
  ) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .s_axil(bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mdl [16];

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: a plain word array, byte lanes merged under the strobe.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    if (addr >= 32'd64) return 2'b10;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) mdl[addr / 4][8*k +: 8] = data[8*k +: 8];
    end
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] addr);
    return (addr < 32'd64) ? mdl[addr / 4] : 32'd0;
  endfunction

  function automatic logic [1:0] model_rresp(input logic [31:0] addr);
    return (addr < 32'd64) ? 2'b00 : 2'b10;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input string tag);
    logic [1:0] got_resp;
    logic [1:0] exp_resp;
    bit         ok;
    bit         bhs;
    int         t;
    fork
      begin
        int tt = 0;
        bit hs = 0;
        repeat (aw_dly) tick();
        bus.AWADDR  = addr;
        bus.AWVALID = 1'b1;
        while (!hs && tt < TMO) begin hs = bus.AWREADY; tick(); tt++; end
        bus.AWVALID = 1'b0;
        check({tag, "_aw_hs"}, 32'(hs), 32'd1);
      end
      begin
        int tt = 0;
        bit hs = 0;
        repeat (w_dly) tick();
        bus.WDATA  = data;
        bus.WSTRB  = strb;
        bus.WVALID = 1'b1;
        while (!hs && tt < TMO) begin hs = bus.WREADY; tick(); tt++; end
        bus.WVALID = 1'b0;
        check({tag, "_w_hs"}, 32'(hs), 32'd1);
      end
    join
    check({tag, "_b_latency"}, 32'(bus.BVALID), 32'd1);
    got_resp = bus.BRESP;
    ok = 1'b1;
    repeat (b_dly) begin
      ok &= bus.BVALID & ~bus.AWREADY & ~bus.WREADY & (bus.BRESP === got_resp);
      tick();
    end
    if (b_dly > 0) check({tag, "_b_stall"}, 32'(ok), 32'd1);
    bus.BREADY = 1'b1;
    bhs = 1'b0;
    t   = 0;
    while (!bhs && t < TMO) begin bhs = bus.BVALID; got_resp = bus.BRESP; tick(); t++; end
    bus.BREADY = 1'b0;
    check({tag, "_b_hs"}, 32'(bhs), 32'd1);
    // Exactly one response: BVALID gone, both write channels open again.
    check({tag, "_after_b"}, {29'd0, bus.BVALID, bus.AWREADY, bus.WREADY}, 32'b011);
    exp_resp = model_write(addr, data, strb);
    check({tag, "_bresp"}, 32'(got_resp), 32'(exp_resp));
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          input string tag, output logic [31:0] data, output logic [1:0] resp);
    int tt;
    bit hs;
    bit ok;
    repeat (ar_dly) tick();
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    hs = 1'b0;
    tt = 0;
    while (!hs && tt < TMO) begin hs = bus.ARREADY; tick(); tt++; end
    bus.ARVALID = 1'b0;
    check({tag, "_ar_hs"}, 32'(hs), 32'd1);
    check({tag, "_r_latency"}, 32'(bus.RVALID), 32'd1);
    data = bus.RDATA;
    resp = bus.RRESP;
    ok = 1'b1;
    repeat (r_dly) begin
      ok &= bus.RVALID & ~bus.ARREADY & (bus.RDATA === data) & (bus.RRESP === resp);
      tick();
    end
    if (r_dly > 0) check({tag, "_r_stall"}, 32'(ok), 32'd1);
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    check({tag, "_after_r"}, {30'd0, bus.RVALID, bus.ARREADY}, 32'b01);
  endtask

  task automatic read_check(input logic [31:0] addr, input int ar_dly, input int r_dly,
                            input string tag);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    logic [31:0] got_d;
    logic [1:0]  got_r;
    exp_d = model_rdata(addr);
    exp_r = model_rresp(addr);
    axi_read(addr, ar_dly, r_dly, tag, got_d, got_r);
    check({tag, "_rdata"}, got_d, exp_d);
    check({tag, "_rresp"}, 32'(got_r), 32'(exp_r));
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    // Reset state and first cycle after release.
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_ctrl", {25'd0, bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                       bus.BRESP == 2'b00, bus.RRESP == 2'b00}, 32'b0000011);
    check("rst_rdata", bus.RDATA, 32'd0);
    ARESET = 1'b1;
    tick();
    check("rdy_after_rst", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'b111);

    // Sequential write then read of every register.
    for (int i = 0; i < 16; i++)
      axi_write(32'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, $sformatf("seq_wr%0d", i));
    for (int i = 0; i < 16; i++) begin
      axi_read(32'(4 * i), 0, 0, $sformatf("seq_rd%0d", i), d, r);
      check($sformatf("seq_rd%0d_val", i), d, 32'(i + 1));
      check($sformatf("seq_rd%0d_resp", i), 32'(r), 32'd0);
    end

    // AW/W skew in both directions with a stalled BREADY.
    axi_write(32'h0C, $urandom, 4'hF, 7, 0, 5, "skew_aw_late");
    read_check(32'h0C, 0, 0, "skew_aw_late_rd");
    axi_write(32'h10, $urandom, 4'hF, 0, 9, 5, "skew_w_late");
    read_check(32'h10, 0, 0, "skew_w_late_rd");

    // Concurrent writes to the low half and reads from the high half.
    fork
      begin
        for (int i = 0; i < 8; i++)
          axi_write(32'(4 * i), $urandom, 4'(($urandom_range(15, 0))),
                    $urandom_range(10, 1), $urandom_range(10, 1), $urandom_range(10, 1),
                    $sformatf("cc_wr%0d", i));
      end
      begin
        for (int i = 0; i < 8; i++)
          read_check(32'(32 + 4 * i), $urandom_range(10, 1), $urandom_range(10, 1),
                     $sformatf("cc_rd%0d", i));
      end
    join
    for (int i = 0; i < 8; i++) read_check(32'(4 * i), 0, 0, $sformatf("cc_chk%0d", i));

    // Same-edge read and write to one address: read sees the old contents.
    fork
      axi_write(32'h18, $urandom, 4'hF, 0, 0, 0, "same_edge_wr");
      read_check(32'h18, 0, 0, "same_edge_rd");
    join
    read_check(32'h18, 0, 0, "same_edge_new");

    // Byte strobes.
    axi_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0, 0, "strb_init");
    axi_write(32'h08, 32'h11223344, 4'b0101, 0, 0, 2, "strb_part");
    axi_read(32'h08, 0, 0, "strb_rd", d, r);
    check("strb_val", d, 32'hAA22CC44);
    axi_write(32'h2A, $urandom, 4'h0, 0, 0, 0, "strb_none");
    read_check(32'h28, 0, 0, "strb_none_rd");

    // Out of range accesses.
    axi_write(32'h40, $urandom, 4'hF, 0, 0, 0, "oor_wr");
    axi_read(32'h7C, 0, 3, "oor_rd", d, r);
    check("oor_rdata", d, 32'd0);
    check("oor_rresp", 32'(r), 32'h2);
    for (int i = 0; i < 16; i++) read_check(32'(4 * i), 0, 0, $sformatf("oor_keep%0d", i));

    // Reset while both a B and an R are pending.
    check("mid_rdy", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'b111);
    bus.AWADDR = 32'h44; bus.AWVALID = 1'b1;
    bus.WDATA = $urandom; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 32'h24; bus.ARVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    check("mid_pending", {30'd0, bus.BVALID, bus.RVALID}, 32'b11);
    check("mid_rdata", bus.RDATA, model_rdata(32'h24));
    check("mid_bresp", 32'(bus.BRESP), 32'h2);
    #2 ARESET = 1'b0;
    #1;
    check("mid_rst_ctrl", {25'd0, bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                           bus.BRESP == 2'b00, bus.RRESP == 2'b00}, 32'b0000011);
    check("mid_rst_rdata", bus.RDATA, 32'd0);
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    repeat (2) tick();
    ARESET = 1'b1;
    tick();
    check("mid_rdy_after", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'b111);
    for (int i = 0; i < 16; i++) read_check(32'(4 * i), 0, 0, $sformatf("post_rst%0d", i));
    axi_write(32'h3C, $urandom, 4'hF, 1, 2, 1, "post_wr");
    read_check(32'h3C, 1, 1, "post_rd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
